i2c_txn_arbiter: RTL and testbench

- Shares one i2c_master instance between NREQ requesters (sensor poller, EEPROM loader, CPU bridge, ...).
- Grants requesters round-robin and programs the master's control, address and count inputs for each granted transaction.
- Streams TX bytes into the master and RX bytes out of it.
- Reports per-transaction completion, NACK and timeout back to the granted requester.

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_txn_arbiter_rr.sv | 34 +++
 rtl/i2c_txn_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg: shared constants and types for the i2c transaction arbiter.
// Revision: 1.0
// ============================================================================
package i2c_pkg;

  // i2c_master control_reg bit positions
  localparam int c_CTL_RSTN = 0;
  localparam int c_CTL_EN   = 1;
  localparam int c_CTL_RW   = 4;
  localparam int c_CTL_REP  = 5;
  localparam int c_CTL_SPD  = 6;

  // i2c_master status_reg bit positions
  localparam int c_ST_BUSY = 0;
  localparam int c_ST_XRDY = 2;
  localparam int c_ST_RRDY = 3;
  localparam int c_ST_NACK = 6;
  localparam int c_ST_STOP = 7;

  localparam logic [1:0] SPD_100K = 2'd0;
  localparam logic [1:0] SPD_400K = 2'd1;
  localparam logic [1:0] SPD_1M   = 2'd2;
  localparam logic [1:0] SPD_3M   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_MRST = 3'd2,
    S_LOAD = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter: combinational round-robin pick of the first request at or
//             after base_i (modulo NREQ).
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   base_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      cand = (int'(base_i) + k) % NREQ;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_txn_arbiter: round-robin sharing of one i2c_master between NREQ
//                  requesters, with TX/RX streaming and per-transaction status.
// Revision: 1.0
// ============================================================================
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int MRST_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TW             = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_len,
  input  logic [2*NREQ-1:0] req_speed,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   grant,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              done,
  output logic              err_nack,
  output logic              err_timeout,
  output logic [7:0]        m_control,
  output logic [7:0]        m_slave_addr,
  output logic [7:0]        m_data_in,
  output logic [7:0]        m_data_count,
  output logic              m_din_write,
  output logic              m_dout_read,
  input  logic [7:0]        m_status,
  input  logic [7:0]        m_data_out
);

  localparam int c_IW = $clog2(NREQ);
  localparam int c_MW = $clog2(MRST_CYCLES + 1);
  localparam logic [TW-1:0] c_TMO = TW'(TIMEOUT_CYCLES);

  state_e            state_q;
  logic [c_IW-1:0]   ptr_q, idx_q;
  logic [NREQ-1:0]   grant_q;
  logic              rw_q, nack_q, busy_seen_q, load_pend_q;
  logic [6:0]        addr_q;
  logic [7:0]        len_q, rem_q;
  logic [1:0]        speed_q;
  logic [c_MW-1:0]   mcnt_q;
  logic [TW-1:0]     wd_q;
  logic [7:0]        st_s1_q, st_q;
  logic [1:0]        st_prev_q;
  logic              tx_ready_q, rx_valid_q, done_q, err_nack_q, err_timeout_q;
  logic              m_din_write_q, m_dout_read_q;
  logic [7:0]        rx_data_q, m_control_q, m_slave_addr_q, m_data_in_q, m_data_count_q;

  logic [NREQ-1:0]   w_gnt;
  logic [c_IW-1:0]   w_idx;
  logic              w_arb_valid;
  logic [6:0]        w_sel_addr;
  logic [7:0]        w_sel_len, w_tx_cur;
  logic [1:0]        w_sel_spd;
  logic              w_xrdy_rise, w_rrdy_rise, w_busy_fall;
  logic              w_unused_st;

  // ptr_q holds the index after the last winner, so its reset value of 0
  // makes requester 0 the first candidate after reset.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req),
    .base_i  (ptr_q),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_arb_valid)
  );

  assign w_sel_addr  = req_addr[32'(w_idx)*7 +: 7];
  assign w_sel_len   = req_len[32'(w_idx)*8 +: 8];
  assign w_sel_spd   = req_speed[32'(w_idx)*2 +: 2];
  assign w_tx_cur    = tx_data[32'(idx_q)*8 +: 8];
  assign w_xrdy_rise = st_q[c_ST_XRDY] & ~st_prev_q[0];
  assign w_rrdy_rise = st_q[c_ST_RRDY] & ~st_prev_q[1];
  assign w_busy_fall = busy_seen_q & ~st_q[c_ST_BUSY];
  assign w_unused_st = ^{st_q[7], st_q[5:4], st_q[1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      grant_q        <= '0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      speed_q        <= '0;
      mcnt_q         <= '0;
      wd_q           <= '0;
      rem_q          <= '0;
      nack_q         <= 1'b0;
      busy_seen_q    <= 1'b0;
      load_pend_q    <= 1'b0;
      st_s1_q        <= '0;
      st_q           <= '0;
      st_prev_q      <= '0;
      tx_ready_q     <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      done_q         <= 1'b0;
      err_nack_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      m_control_q    <= '0;
      m_slave_addr_q <= '0;
      m_data_in_q    <= '0;
      m_data_count_q <= '0;
      m_din_write_q  <= 1'b0;
      m_dout_read_q  <= 1'b0;
    end else begin
      st_s1_q       <= m_status;
      st_q          <= st_s1_q;
      st_prev_q     <= {st_q[c_ST_RRDY], st_q[c_ST_XRDY]};
      tx_ready_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      m_din_write_q <= 1'b0;
      m_dout_read_q <= 1'b0;
      load_pend_q   <= 1'b0;

      case (state_q)
        S_IDLE: if (|req) state_q <= S_ARB;

        S_ARB: begin
          if (w_arb_valid) begin
            grant_q     <= w_gnt;
            idx_q       <= w_idx;
            rw_q        <= req_rw[w_idx];
            addr_q      <= w_sel_addr;
            len_q       <= (w_sel_len == 8'd0) ? 8'd1 : w_sel_len;
            speed_q     <= w_sel_spd;
            ptr_q       <= (w_idx == c_IW'(NREQ - 1)) ? '0 : w_idx + c_IW'(1);
            mcnt_q      <= '0;
            m_control_q <= '0;
            state_q     <= S_MRST;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_MRST: begin
          if (mcnt_q == c_MW'(MRST_CYCLES - 1)) begin
            m_slave_addr_q <= {1'b0, addr_q};
            m_data_count_q <= len_q;
            m_data_in_q    <= rw_q ? 8'h00 : w_tx_cur;
            state_q        <= S_LOAD;
          end else begin
            mcnt_q <= mcnt_q + c_MW'(1);
          end
        end

        S_LOAD: begin
          m_control_q <= {speed_q, 1'b0, rw_q, 2'b00, 1'b1, 1'b1};
          wd_q        <= '0;
          nack_q      <= 1'b0;
          busy_seen_q <= 1'b0;
          rem_q       <= len_q;
          state_q     <= S_RUN;
        end

        S_RUN: begin
          if (wd_q != '1) wd_q <= wd_q + TW'(1);
          if (st_q[c_ST_BUSY]) busy_seen_q <= 1'b1;
          if (st_q[c_ST_NACK]) nack_q <= 1'b1;

          if (!rw_q && w_xrdy_rise) begin
            m_din_write_q <= 1'b1;
            if (rem_q != 8'd0) begin
              tx_ready_q <= 1'b1;
              rem_q      <= rem_q - 8'd1;
            end
          end
          // Reload one cycle after tx_ready so the requester has advanced.
          if (tx_ready_q) load_pend_q <= 1'b1;
          if (load_pend_q) m_data_in_q <= w_tx_cur;

          if (rw_q && w_rrdy_rise) begin
            rx_data_q     <= m_data_out;
            rx_valid_q    <= 1'b1;
            m_dout_read_q <= 1'b1;
          end

          // A byte arriving with busy-fall is delivered first; exit next cycle.
          if (wd_q >= c_TMO) begin
            done_q           <= 1'b1;
            err_timeout_q    <= 1'b1;
            err_nack_q       <= nack_q | st_q[c_ST_NACK];
            m_control_q[1:0] <= 2'b00;
            state_q          <= S_DONE;
          end else if (w_busy_fall && !(rw_q && w_rrdy_rise)) begin
            done_q           <= 1'b1;
            err_nack_q       <= nack_q | st_q[c_ST_NACK];
            m_control_q[1:0] <= 2'b00;
            state_q          <= S_DONE;
          end
        end

        S_DONE: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign tx_ready     = tx_ready_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign done         = done_q;
  assign err_nack     = err_nack_q;
  assign err_timeout  = err_timeout_q;
  assign m_control    = m_control_q;
  assign m_slave_addr = m_slave_addr_q;
  assign m_data_in    = m_data_in_q;
  assign m_data_count = m_data_count_q;
  assign m_din_write  = m_din_write_q;
  assign m_dout_read  = m_dout_read_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// tb_i2c_txn_arbiter: scoreboard bench with a behavioural i2c_master model.
// Revision: 1.0
// ============================================================================
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0, req_rw = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_len = '0;
  logic [7:0]  req_speed = '0;
  logic [31:0] tx_data;
  logic [3:0]  grant;
  logic        tx_ready, rx_valid, done, err_nack, err_timeout;
  logic [7:0]  rx_data, m_control, m_slave_addr, m_data_in, m_data_count;
  logic        m_din_write, m_dout_read;
  logic [7:0]  m_status = '0, m_data_out = '0;

  typedef struct packed {
    logic [3:0] g;
    logic       nk;
    logic       to;
  } done_t;

  done_t      exp_done[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] wr_bytes[4];
  logic [7:0] rd_src[4];
  int wr_pos = 0, wr_base = 0, wr_req = 0;
  int n_txr = 0, n_dinw = 0, n_done = 0;
  int n_chk = 0, n_err = 0;

  i2c_txn_arbiter #(
    .NREQ(4), .MRST_CYCLES(8), .TIMEOUT_CYCLES(100), .TW(18)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .req_speed(req_speed), .tx_data(tx_data),
    .grant(grant), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .done(done), .err_nack(err_nack), .err_timeout(err_timeout),
    .m_control(m_control), .m_slave_addr(m_slave_addr), .m_data_in(m_data_in),
    .m_data_count(m_data_count), .m_din_write(m_din_write), .m_dout_read(m_dout_read),
    .m_status(m_status), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  // Requester: presents its current write byte, advancing on tx_ready.
  always_comb begin
    tx_data = '0;
    tx_data[wr_req*8 +: 8] = (wr_pos - wr_base < 4) ? wr_bytes[wr_pos - wr_base] : 8'h00;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (tx_ready) begin wr_pos++; n_txr++; end
      if (m_din_write) n_dinw++;
      if (rx_valid) begin
        if (exp_rx.size() == 0) check_eq("rx_unexpected", 32'(rx_valid), 32'd0);
        else check_eq("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (done) begin
        done_t d;
        check_eq("rx_before_done", 32'(exp_rx.size()), 32'd0);
        if (exp_done.size() == 0) check_eq("done_unexpected", 32'(done), 32'd0);
        else begin
          d = exp_done.pop_front();
          check_eq("done_grant", 32'(grant), 32'(d.g));
          check_eq("err_nack", 32'(err_nack), 32'(d.nk));
          check_eq("err_timeout", 32'(err_timeout), 32'(d.to));
        end
        n_done++;
      end
    end
  end

  task automatic master_run(input logic [7:0] ectl, input logic [7:0] eaddr,
                            input logic [7:0] ecnt, input int nb, input bit rd,
                            input bit nack, input bit hang);
    int t;
    t = 0;
    while (!m_control[1] && t < 200) begin @(negedge clk); t++; end
    check_eq("enable_seen", 32'(m_control[1]), 32'd1);
    check_eq("m_control", 32'(m_control), 32'(ectl));
    check_eq("m_slave_addr", 32'(m_slave_addr), 32'(eaddr));
    check_eq("m_data_count", 32'(m_data_count), 32'(ecnt));
    repeat (2) @(negedge clk);
    m_status[0] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      repeat (5) @(negedge clk);
      if (rd) begin
        m_data_out  = rd_src[b];
        m_status[3] = 1'b1;
        if (b == nb - 1 && !hang) m_status[0] = 1'b0;
      end else begin
        if (exp_tx.size() > 0) check_eq("tx_byte", 32'(m_data_in), 32'(exp_tx.pop_front()));
        m_status[2] = 1'b1;
      end
      repeat (3) @(negedge clk);
      m_status[3:2] = 2'b00;
    end
    if (nack) begin m_status[6] = 1'b1; repeat (2) @(negedge clk); end
    if (!hang) begin repeat (2) @(negedge clk); m_status = 8'h00; end
  endtask

  task automatic wait_done(input int n0);
    int t;
    t = 0;
    while (n_done == n0 && t < 400) begin @(negedge clk); t++; end
    check_eq("done_seen", 32'(n_done - n0), 32'd1);
  endtask

  task automatic set_fields(input int r, input bit rd, input logic [6:0] a,
                            input logic [7:0] len, input logic [1:0] spd);
    req_rw[r]           = rd;
    req_addr[r*7 +: 7]  = a;
    req_len[r*8 +: 8]   = len;
    req_speed[r*2 +: 2] = spd;
  endtask

  task automatic do_txn(input int r, input bit rd, input logic [6:0] a,
                        input logic [7:0] len, input logic [1:0] spd,
                        input int nb, input bit nack, input bit hang);
    int n0;
    n0 = n_done;
    set_fields(r, rd, a, len, spd);
    req[r] = 1'b1;
    exp_done.push_back('{g: 4'(1 << r), nk: nack, to: hang});
    master_run({spd, 1'b0, rd, 2'b00, 2'b11}, {1'b0, a}, (len == 0) ? 8'd1 : len,
               nb, rd, nack, hang);
    wait_done(n0);
    req[r] = 1'b0;
  endtask

  task automatic setup_write(input int r, input logic [7:0] b0, input logic [7:0] b1);
    wr_req = r; wr_base = wr_pos;
    wr_bytes[0] = b0; wr_bytes[1] = b1; wr_bytes[2] = 8'h00; wr_bytes[3] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int txr0, dinw0, t;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_m_control", 32'(m_control), 32'd0);
    check_eq("rst_pulses", 32'({tx_ready, rx_valid, done, err_nack, err_timeout, m_din_write, m_dout_read}), 32'd0);
    check_eq("rst_m_regs", {m_slave_addr, m_data_in, m_data_count, rx_data}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-byte write from requester 0.
    setup_write(0, 8'hA5, 8'h3C);
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C);
    txr0 = n_txr; dinw0 = n_dinw;
    do_txn(0, 1'b0, 7'h50, 8'd2, 2'd0, 2, 1'b0, 1'b0);
    check_eq("wr_tx_ready_cnt", 32'(n_txr - txr0), 32'd2);
    check_eq("wr_din_write_cnt", 32'(n_dinw - dinw0), 32'd2);
    repeat (3) @(negedge clk);

    // Three-byte read from requester 2; last byte coincides with busy-fall.
    rd_src[0] = 8'h11; rd_src[1] = 8'h22; rd_src[2] = 8'h33;
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33);
    do_txn(2, 1'b1, 7'h3A, 8'd3, 2'd2, 3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // len=0 behaves as 1; a surplus xrdy gets din_write but no tx_ready.
    setup_write(1, 8'h77, 8'h00);
    exp_tx.push_back(8'h77);
    txr0 = n_txr; dinw0 = n_dinw;
    do_txn(1, 1'b0, 7'h21, 8'd0, 2'd1, 2, 1'b0, 1'b0);
    check_eq("len0_tx_ready_cnt", 32'(n_txr - txr0), 32'd1);
    check_eq("len0_din_write_cnt", 32'(n_dinw - dinw0), 32'd2);
    repeat (3) @(negedge clk);

    // NACK from requester 3.
    setup_write(3, 8'h5A, 8'h00);
    exp_tx.push_back(8'h5A);
    do_txn(3, 1'b0, 7'h68, 8'd1, 2'd3, 1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Busy stuck high: watchdog ends the transaction.
    setup_write(1, 8'hC3, 8'h00);
    exp_tx.push_back(8'hC3);
    do_txn(1, 1'b0, 7'h2B, 8'd1, 2'd0, 1, 1'b0, 1'b1);
    check_eq("tmo_m_control", 32'(m_control), 32'd0);
    m_status = 8'h00;
    repeat (3) @(negedge clk);

    // Reset mid-RUN, then round-robin with every requester pending.
    setup_write(1, 8'h99, 8'h00);
    set_fields(1, 1'b0, 7'h44, 8'd2, 2'd0);
    req[1] = 1'b1;
    t = 0;
    while (!m_control[1] && t < 200) begin @(negedge clk); t++; end
    m_status = 8'h01;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mid_grant", 32'(grant), 32'd0);
    check_eq("rst_mid_m_control", 32'(m_control), 32'd0);
    m_status = 8'h00;
    exp_tx.delete();
    for (int r = 0; r < 4; r++) set_fields(r, 1'b1, 7'(8'h10 + r), 8'd1, 2'(r));
    req = 4'b1111;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      int r, n0;
      r = i % 4;
      t = 0;
      while (grant != 4'b0000 && t < 20) begin @(negedge clk); t++; end
      t = 0;
      while (grant == 4'b0000 && t < 20) begin @(negedge clk); t++; end
      check_eq("rr_grant", 32'(grant), 32'(1 << r));
      n0 = n_done;
      rd_src[0] = 8'(8'h40 + r);
      exp_rx.push_back(8'(8'h40 + r));
      exp_done.push_back('{g: 4'(1 << r), nk: 1'b0, to: 1'b0});
      master_run({2'(r), 1'b0, 1'b1, 2'b00, 2'b11}, 8'(8'h10 + r), 8'd1, 1, 1'b1, 1'b0, 1'b0);
      wait_done(n0);
    end
    req = 4'b0000;
    repeat (5) @(negedge clk);
    check_eq("end_exp_done_empty", 32'(exp_done.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
